par_bus_bridge: RTL

//  Parametrised Raspberry Pi parallel-bus slave for the hashing accelerators. Samples the

---
 rtl/par_bus_bridge.sv | 135 +++++++++++++
 1 files changed

// File: rtl/par_bus_bridge.sv
// Parallel-bus slave: synchronises the master strobe/data into clk and bridges bus words
// to/from RX and TX FIFOs exposed as valid/ready streams, with sticky overflow/underflow flags.
module par_bus_bridge #(
    parameter int                    DATA_WIDTH  = 8,
    parameter int                    RX_DEPTH    = 16,
    parameter int                    TX_DEPTH    = 16,
    parameter int                    SYNC_STAGES = 2,
    parameter logic [DATA_WIDTH-1:0] IDLE_WORD   = '0
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        bus_clk,
    input  logic                        bus_rnw,
    input  logic [DATA_WIDTH-1:0]       bus_data_in,
    output logic [DATA_WIDTH-1:0]       bus_data_out,
    output logic                        bus_data_oe,
    output logic [DATA_WIDTH-1:0]       rx_tdata,
    output logic                        rx_tvalid,
    input  logic                        rx_tready,
    input  logic [DATA_WIDTH-1:0]       tx_tdata,
    input  logic                        tx_tvalid,
    output logic                        tx_tready,
    input  logic                        clear,
    output logic                        rx_overflow,
    output logic                        tx_underflow,
    output logic [$clog2(RX_DEPTH):0]   rx_level
);
    localparam int RXA = $clog2(RX_DEPTH);
    localparam int TXA = $clog2(TX_DEPTH);
    localparam logic [RXA:0] RX_ONE = 1;
    localparam logic [TXA:0] TX_ONE = 1;

    logic [SYNC_STAGES-1:0]                 clk_sync, rnw_sync;
    logic [SYNC_STAGES-1:0][DATA_WIDTH-1:0] data_sync;
    logic                                   clk_d;
    logic                                   clk_s, rnw_s, strobe_edge, wr_edge, rd_edge;
    logic [DATA_WIDTH-1:0]                  data_s;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clk_sync    <= '0;
            rnw_sync    <= '0;
            data_sync   <= '0;
            clk_d       <= 1'b0;
            bus_data_oe <= 1'b0;
        end else begin
            clk_sync    <= {clk_sync[SYNC_STAGES-2:0], bus_clk};
            rnw_sync    <= {rnw_sync[SYNC_STAGES-2:0], bus_rnw};
            data_sync   <= {data_sync[SYNC_STAGES-2:0], bus_data_in};
            clk_d       <= clk_s;
            bus_data_oe <= rnw_s;
        end
    end

    assign clk_s       = clk_sync[SYNC_STAGES-1];
    assign rnw_s       = rnw_sync[SYNC_STAGES-1];
    assign data_s      = data_sync[SYNC_STAGES-1];
    assign strobe_edge = clk_s & ~clk_d;
    // clear swallows any strobe edge landing in the same cycle
    assign wr_edge     = strobe_edge & ~rnw_s & ~clear;
    assign rd_edge     = strobe_edge &  rnw_s & ~clear;

    // RX FIFO: bus -> stream
    logic [DATA_WIDTH-1:0] rx_mem [RX_DEPTH];
    logic [RXA:0]          rx_wptr, rx_rptr;
    logic                  rx_full, rx_pop, rx_push, rx_drop;

    assign rx_level  = rx_wptr - rx_rptr;
    assign rx_tvalid = (rx_wptr != rx_rptr);
    assign rx_full   = (rx_wptr[RXA] != rx_rptr[RXA]) && (rx_wptr[RXA-1:0] == rx_rptr[RXA-1:0]);
    assign rx_tdata  = rx_mem[rx_rptr[RXA-1:0]];
    assign rx_pop    = rx_tvalid & rx_tready & ~clear;
    assign rx_push   = wr_edge & (~rx_full | rx_pop);
    assign rx_drop   = wr_edge & rx_full & ~rx_pop;

    always_ff @(posedge clk) begin
        if (rx_push) rx_mem[rx_wptr[RXA-1:0]] <= data_s;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_wptr     <= '0;
            rx_rptr     <= '0;
            rx_overflow <= 1'b0;
        end else if (clear) begin
            rx_wptr     <= '0;
            rx_rptr     <= '0;
            rx_overflow <= 1'b0;
        end else begin
            if (rx_push) rx_wptr <= rx_wptr + RX_ONE;
            if (rx_pop)  rx_rptr <= rx_rptr + RX_ONE;
            if (rx_drop) rx_overflow <= 1'b1;
        end
    end

    // TX FIFO: stream -> bus
    logic [DATA_WIDTH-1:0] tx_mem [TX_DEPTH];
    logic [TXA:0]          tx_wptr, tx_rptr;
    logic                  tx_full, tx_empty, tx_pop, tx_push;

    assign tx_empty  = (tx_wptr == tx_rptr);
    assign tx_full   = (tx_wptr[TXA] != tx_rptr[TXA]) && (tx_wptr[TXA-1:0] == tx_rptr[TXA-1:0]);
    // a bus read frees a slot in the same cycle, so a full FIFO can still accept
    assign tx_tready = ~tx_full | rd_edge;
    assign tx_push   = tx_tvalid & tx_tready & ~clear;
    assign tx_pop    = rd_edge & ~tx_empty;

    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wptr[TXA-1:0]] <= tx_tdata;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_wptr      <= '0;
            tx_rptr      <= '0;
            tx_underflow <= 1'b0;
            bus_data_out <= IDLE_WORD;
        end else if (clear) begin
            tx_wptr      <= '0;
            tx_rptr      <= '0;
            tx_underflow <= 1'b0;
        end else begin
            if (tx_push) tx_wptr <= tx_wptr + TX_ONE;
            if (tx_pop)  tx_rptr <= tx_rptr + TX_ONE;
            if (rd_edge) begin
                if (tx_empty) begin
                    bus_data_out <= IDLE_WORD;
                    tx_underflow <= 1'b1;
                end else begin
                    bus_data_out <= tx_mem[tx_rptr[TXA-1:0]];
                end
            end
        end
    end
endmodule
